uart_tx_framed: RTL
===================

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal range 1..2.
REQ-004 SHALL have port i_Clock, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port i_Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_Tx_DV, input, 1: transmit request (valid).
REQ-007 SHALL have port o_Tx_Ready, output, 1: block accepts a request this cycle.
REQ-008 SHALL have port i_Tx_Byte, input, DATA_BITS: frame payload.
REQ-009 SHALL have port i_Parity_Odd, input, 1: 1 = odd parity, 0 = even parity; sampled at accept.
REQ-010 SHALL have port o_Tx_Serial, output, 1: serial line; idle high.
REQ-011 SHALL have port o_Tx_Active, output, 1: a frame is on the line.
REQ-012 SHALL have port o_Tx_Done, output, 1: one-cycle frame-complete pulse.

Function
REQ-013 SHALL accept a frame on a rising edge where i_Tx_DV=1 and o_Tx_Ready=1, latching i_Tx_Byte and i_Parity_Odd at that edge.
REQ-014 SHALL drive o_Tx_Ready high in IDLE and in the last clock of the final stop bit, and low otherwise.
REQ-015 SHALL ignore i_Tx_DV while o_Tx_Ready=0; input changes during a frame SHALL NOT affect it.
REQ-016 SHALL implement states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on an accept in the last stop cycle. There is no cleanup state.
REQ-017 SHALL begin the start bit (0) in the cycle after accept, and hold every bit for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL send data LSB first and send STOP_BITS stop bits (1).
REQ-019 SHALL make frame length (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
REQ-020 SHALL send back-to-back frames with no idle bit between them, and hold o_Tx_Active continuously high across them.
REQ-021 SHALL assert o_Tx_Active from the cycle after accept through the last stop cycle.
REQ-022 SHALL pulse o_Tx_Done for exactly one cycle, in the cycle after the last stop cycle; in back-to-back operation this coincides with the next start bit.
REQ-023 SHALL size the bit-period counter to $clog2(CLKS_PER_BIT) bits, and the bit index to $clog2(DATA_BITS) bits.
REQ-024 SHALL fail elaboration for illegal parameter values.

Reset
REQ-025 SHALL, while i_Reset=1, force state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=0, and counters to 0.
REQ-026 SHALL abort a frame on reset mid-frame: line high in the next cycle, no o_Tx_Done pulse.
REQ-027 SHALL raise o_Tx_Ready=1 in the first cycle after i_Reset deasserts.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert one parity bit after the data bits: even parity = XOR of the data bits, odd parity = its inverse.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and bit and ignore i_Parity_Odd; the port remains present.

Structure
REQ-030 SHALL place the state-encoding typedef (IDLE, START, DATA, PARITY, STOP) and the parameter range-limit constants in shared package uart_pkg.
REQ-031 SHALL use sub-module uart_baud_cnt: a CLKS_PER_BIT down-counter producing a bit-end strobe, reloaded on accept.

Verification
REQ-032 SHALL cover: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no parity, send 0xA5 at cycle 0 -> line 0,1,0,1,0,0,1,0,1,1 for 4 cycles each over cycles 1..40; o_Tx_Active high 1..40; o_Tx_Done pulse at cycle 41.
REQ-033 SHALL cover: i_Tx_DV held high with 0x00 then 0xFF -> second start bit at cycle 41 with no idle gap; o_Tx_Active never drops; two o_Tx_Done pulses, 40 cycles apart.
REQ-034 SHALL cover: UART_TX_PARITY_EN defined, 0x07 sent -> parity bit 0 when i_Parity_Odd=1 and 1 when i_Parity_Odd=0; frame is 44 cycles.
REQ-035 SHALL cover: DATA_BITS=7, STOP_BITS=2, send 0x7F -> line high for 8 cycles after the data bits; o_Tx_Done at cycle 41.
REQ-036 SHALL cover: i_Reset pulsed during data bit 3 -> o_Tx_Serial=1 next cycle, o_Tx_Active=0, no o_Tx_Done, o_Tx_Ready=1 one cycle after release.
REQ-037 SHALL cover: i_Tx_DV pulsed with 0x55 mid-frame -> ignored; only the original frame is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: state encoding and
// the legal parameter limits checked at elaboration.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MIN_CLKS_PER_BIT = 2;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 9;
    localparam int MIN_STOP_BITS    = 1;
    localparam int MAX_STOP_BITS    = 2;

endpackage

// File: rtl/uart_tx_framed_if.sv
// Request/line bundle of the framed UART transmitter; master is the producer
// of bytes, slave is the transmitter side.
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_dv;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 parity_odd;
    logic                 tx_serial;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        output tx_dv, tx_byte, parity_odd,
        input  tx_ready, tx_serial, tx_active, tx_done
    );

    modport slave (
        input  tx_dv, tx_byte, parity_odd,
        output tx_ready, tx_serial, tx_active, tx_done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reloads on accept, wraps at each bit end and
// flags both the last cycle of a bit and the cycle before it.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic bit_end,
    output logic near_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks
        $error("uart_baud_cnt: CLKS_PER_BIT must be at least 2");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (run) begin
            count <= (count == '0) ? RELOAD : count - 1'b1;
        end
    end

    assign bit_end  = run && (count == '0);
    assign near_end = run && (count == CW'(1));

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with back-to-back support.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    output logic                 o_Tx_Ready,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic                 i_Parity_Odd,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop
        $error("uart_tx_framed: STOP_BITS must be 1..2");
    end

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 accept;
    logic                 bit_end;
    logic                 near_end;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`else
    logic unused_parity;
    assign unused_parity = i_Parity_Odd;
`endif

    assign accept = i_Tx_DV && o_Tx_Ready;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .load    (accept),
        .run     (o_Tx_Active),
        .bit_end (bit_end),
        .near_end(near_end)
    );

    // Ready is registered one cycle ahead: it rises when the counter is one
    // cycle from the end of the final stop bit, so a new frame can be
    // accepted in that last cycle without an idle gap.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            o_Tx_Ready  <= 1'b0;
            shift       <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            o_Tx_Done  <= 1'b0;
            o_Tx_Ready <= 1'b0;

            if (accept) begin
                shift   <= i_Tx_Byte;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^i_Tx_Byte) ^ i_Parity_Odd;
`endif
            end

            case (state)
                IDLE: begin
                    o_Tx_Ready <= 1'b1;
                    if (accept) begin
                        state       <= START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        o_Tx_Ready  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state       <= DATA;
                        o_Tx_Serial <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state       <= PARITY;
                            o_Tx_Serial <= parity_bit;
`else
                            state       <= STOP;
                            o_Tx_Serial <= 1'b1;
                            stop_idx    <= 1'b0;
`endif
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            shift       <= shift >> 1;
                            o_Tx_Serial <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state       <= STOP;
                        o_Tx_Serial <= 1'b1;
                        stop_idx    <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_end && stop_idx == LAST_STOP) begin
                        o_Tx_Done <= 1'b1;
                        if (accept) begin
                            state       <= START;
                            o_Tx_Serial <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            o_Tx_Serial <= 1'b1;
                            o_Tx_Active <= 1'b0;
                            o_Tx_Ready  <= 1'b1;
                        end
                    end else begin
                        if (bit_end) begin
                            stop_idx <= 1'b1;
                        end
                        o_Tx_Ready <= near_end && (stop_idx == LAST_STOP);
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule
